taskfun_serial_sub: RTL



---
 rtl/taskfun_pkg.sv | 14 +
 rtl/taskfun_fs_cell.sv | 15 +
 rtl/taskfun_serial_sub.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/taskfun_pkg.sv
// Shared definitions for the taskfun arithmetic blocks.
// Contents: FSM state type, default operand width, default bit-counter width.
package taskfun_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/taskfun_fs_cell.sv
// 1-bit combinational full subtractor: d = s - b - bw_i, with borrow out.
// Ports: s_i minuend bit, b_i subtrahend bit, bw_i borrow in,
//        d_o difference bit, bw_o borrow out.
module taskfun_fs_cell (
    input  logic s_i,
    input  logic b_i,
    input  logic bw_i,
    output logic d_o,
    output logic bw_o
);

    assign d_o  = s_i ^ b_i ^ bw_i;
    assign bw_o = (~s_i & b_i) | (~(s_i ^ b_i) & bw_i);

endmodule

// File: rtl/taskfun_serial_sub.sv
// Bit-serial subtractor: recovers diff = sum - b, LSB first, one bit per clock,
// with valid/ready handshakes on input and output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only when idle)
//   sum [WIDTH:0]       minuend
//   b   [WIDTH-1:0]     subtrahend, zero-extended
//   out_valid/out_ready result handshake
//   diff [WIDTH:0]      (sum - b) mod 2^(WIDTH+1), held until next result
//   borrow              1 when b > sum
// Build option: TASKFUN_SUB_SAT_EN clamps diff to 0 when borrow is set.
module taskfun_serial_sub
    import taskfun_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH:0]     sum_q, sum_d;
    logic [WIDTH:0]     b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bw_q, bw_d;
    logic [WIDTH:0]     diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               d_c;
    logic               bw_next_c;

    // Current bit: LSBs of both operand registers plus the running borrow
    taskfun_fs_cell u_fs_cell (
        .s_i  (sum_q[0]),
        .b_i  (b_q[0]),
        .bw_i (bw_q),
        .d_o  (d_c),
        .bw_o (bw_next_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            bw_q        <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            bw_q        <= bw_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        bw_d        = bw_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sum_d      = sum;
                    b_d        = {1'b0, b};
                    res_d      = '0;
                    cnt_d      = '0;
                    bw_d       = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                sum_d = sum_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_c, res_q[WIDTH-1:1]};
                bw_d  = bw_next_c;
                cnt_d = cnt_q + CNT_W'(1);
                // Last bit goes straight into diff; res_q already holds bits 0..WIDTH-1
                if (cnt_q == CNT_W'(WIDTH)) begin
                    diff_d      = {d_c, res_q};
                    borrow_d    = bw_next_c;
`ifdef TASKFUN_SUB_SAT_EN
                    if (bw_next_c) begin
                        diff_d = '0;
                    end
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule
